uart_rx: RTL and testbench

Standalone UART receiver: it recovers 8-bit frames from the serial `rx` line and buffers them in a small FIFO for a parallel consumer. It is the receiving end of the serial link driven by the existing `uart` block's `tx` pin, and it uses the same `rd_en`/`rd_rdy`/`dout` read handshake. It provides mid-bit sampling, false-start rejection, framing-error and overrun reporting, and optional even parity.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_rx.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 4;
  localparam int DEPTH_DEF        = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO with wrap-bit pointers.
// Guards itself against push-when-full (unless popping) and pop-when-empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 empty,
  output logic                 full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;
  logic                 w_wr;
  logic                 w_rd;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign rdata = r_mem[r_rptr[AW-1:0]];

  // A full FIFO still accepts a write when the head slot is freed this cycle.
  assign w_wr = push && (!full || pop);
  assign w_rd = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, mid-bit sampling FSM, error flags and FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit between D7 and stop.
//
// state     | meaning
// ST_IDLE   | wait for a 1->0 edge on the synchronized line
// ST_START  | confirm start bit at its midpoint (reject glitches)
// ST_DATA   | sample 8 data bits, LSB first
// ST_PARITY | sample even-parity bit (parity builds only)
// ST_STOP   | sample stop bit, then push or flag
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic                 rd_rdy,
  output logic [DATA_BITS-1:0] dout,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  logic                 w_rx_s;

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;

  logic                 w_cnt_clr;
  logic                 w_shift_en;
  logic                 w_par_en;
  logic                 w_stop_en;
  logic                 w_par_bad;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic [DATA_BITS-1:0] w_rdata;

  logic                 r_frame_err;
  logic                 r_overrun;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s && r_rx_prev) begin
          w_state_nxt = ST_START;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_shift_en = 1'b1;
          w_cnt_clr  = 1'b1;
          if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_par_en    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_stop_en   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state == ST_IDLE || w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state != ST_DATA) begin
        r_idx <= '0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_shift_en) begin
        r_shift[r_idx] <= w_rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_en) begin
        r_par_bad <= ^{r_shift, w_rx_s};
      end
      r_parity_err <= w_stop_en && r_par_bad;
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign w_push = w_stop_en && w_rx_s && !w_par_bad;
  assign w_pop  = rd_en && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_en && !w_rx_s;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .wdata(r_shift),
    .pop  (w_pop),
    .rdata(w_rdata),
    .empty(w_empty),
    .full (w_full)
  );

  assign rd_rdy    = !w_empty;
  assign dout      = w_rdata;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=4, DEPTH=4.
// Parity steps run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       rd_rdy;
  logic [7:0] dout;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_tot  = 0;
  int n_pass = 0;
  int n_fe   = 0;
  int n_pe   = 0;
  int n_ov   = 0;
  int b_fe, b_pe, b_ov;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_rdy    (rd_rdy),
    .dout      (dout),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Count high cycles of each flag; a lone pulse adds exactly one.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frame_err === 1'b1)  n_fe++;
      if (parity_err === 1'b1) n_pe++;
      if (overrun === 1'b1)    n_ov++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic mark();
    b_fe = n_fe;
    b_pe = n_pe;
    b_ov = n_ov;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_b);
    drive_bit(1'b1);
  endtask
`endif

  task automatic pop_chk(input string tag, input logic [7:0] exp_d);
    chk({tag, "_rdy"}, 32'(rd_rdy), 32'd1);
    chk({tag, "_dout"}, 32'(dout), 32'(exp_d));
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rdy",  32'(rd_rdy),     32'd0);
    chk("rst_dout", 32'(dout),       32'd0);
    chk("rst_fe",   32'(frame_err),  32'd0);
    chk("rst_pe",   32'(parity_err), 32'd0);
    chk("rst_ov",   32'(overrun),    32'd0);
    idle(4);

    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("empty_pop_rdy", 32'(rd_rdy), 32'd0);

    mark();
    send_frame(8'h7D, 1'b1);
    idle(3);
    pop_chk("single", 8'h7D);
    chk("single_after_pop", 32'(rd_rdy), 32'd0);
    chk("single_fe", 32'(n_fe - b_fe), 32'd0);
    chk("single_pe", 32'(n_pe - b_pe), 32'd0);
    chk("single_ov", 32'(n_ov - b_ov), 32'd0);

    mark();
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("glitch_state", 32'(dut.r_state), 32'(ST_IDLE));
    idle(20);
    chk("glitch_rdy", 32'(rd_rdy), 32'd0);
    chk("glitch_fe",  32'(n_fe - b_fe), 32'd0);

    mark();
    send_frame(8'h55, 1'b0);
    idle(8);
    chk("ferr_pulse", 32'(n_fe - b_fe), 32'd1);
    chk("ferr_rdy",   32'(rd_rdy), 32'd0);
    send_frame(8'hA3, 1'b1);
    idle(3);
    pop_chk("ferr_next", 8'hA3);
    chk("ferr_next_empty", 32'(rd_rdy), 32'd0);
    chk("ferr_once", 32'(n_fe - b_fe), 32'd1);

    mark();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    chk("ovr_none_yet", 32'(n_ov - b_ov), 32'd0);
    send_frame(8'h05, 1'b1);
    idle(3);
    chk("ovr_pulse", 32'(n_ov - b_ov), 32'd1);
    chk("ovr_fe",    32'(n_fe - b_fe), 32'd0);
    for (int i = 1; i <= 4; i++) pop_chk("ovr_read", 8'(i));
    chk("ovr_drained", 32'(rd_rdy), 32'd0);

    send_frame(8'h11, 1'b1);
    idle(3);
    chk("prerst_rdy", 32'(rd_rdy), 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst = 1'b1;
    #2;
    chk("inrst_rdy",  32'(rd_rdy), 32'd0);
    chk("inrst_dout", 32'(dout),   32'd0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12);
    chk("postrst_rdy",  32'(rd_rdy),    32'd0);
    chk("postrst_dout", 32'(dout),      32'd0);
    chk("postrst_fe",   32'(frame_err), 32'd0);
    mark();
    send_frame(8'h2F, 1'b1);
    idle(3);
    pop_chk("postrst", 8'h2F);
    chk("postrst_empty", 32'(rd_rdy), 32'd0);
    chk("postrst_flags", 32'((n_fe - b_fe) + (n_ov - b_ov)), 32'd0);

`ifdef UART_RX_PARITY_EN
    mark();
    send_frame_par(8'h2F, 1'b1);
    idle(3);
    pop_chk("par_good", 8'h2F);
    chk("par_good_pe", 32'(n_pe - b_pe), 32'd0);
    send_frame_par(8'h2F, 1'b0);
    idle(3);
    chk("par_bad_pe",  32'(n_pe - b_pe), 32'd1);
    chk("par_bad_rdy", 32'(rd_rdy), 32'd0);
    chk("par_bad_fe",  32'(n_fe - b_fe), 32'd0);
`else
    chk("nopar_pe", 32'(parity_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
